// File: rtl/mutation_pkg.sv
// Shared types and default sizing for the GA bit-flip mutation stage.
// Build option MUTATION_STATS_EN adds a saturating total_mut counter to the top.
package mutation_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH      = 8;
  localparam int GENE_WIDTH = 8;
  localparam int NUM_GENES  = 4;
  localparam int GENE_IDX_W = $clog2(GENE_WIDTH);
  localparam int GIDX_W     = (NUM_GENES > 1) ? $clog2(NUM_GENES) : 1;
  localparam int CNT_W      = $clog2(NUM_GENES + 1);

  // Sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/mutation_gene_flip.sv
// Combinational single-gene mutator: inverts one selected bit when hit is set.
module mutation_gene_flip #(
  parameter int GeneWidth = 8,
  parameter int IdxW      = 3
) (
  input  logic [GeneWidth-1:0] gene_i,
  input  logic                 hit_i,
  input  logic [IdxW-1:0]      bit_idx_i,
  output logic [GeneWidth-1:0] gene_o
);

  logic [GeneWidth-1:0] flip_mask_s;

  // One-hot mask at the chosen bit, gated by the hit decision.
  always_comb begin
    flip_mask_s            = {GeneWidth{1'b0}};
    flip_mask_s[bit_idx_i] = hit_i;
    gene_o                 = gene_i ^ flip_mask_s;
  end

endmodule

// File: rtl/lca_mutation_unit.sv
// Bit-flip mutation stage: two RandomicLCA words per gene (hit test, bit select).
// Optional MUTATION_STATS_EN adds output total_mut, a saturating sum of mut_count.
module lca_mutation_unit
  import mutation_pkg::*;
#(
  parameter int Width     = WIDTH,
  parameter int GeneWidth = GENE_WIDTH,
  parameter int NumGenes  = NUM_GENES,
  localparam int ChromWidth = GeneWidth * NumGenes,
  localparam int GeneIdxW   = $clog2(GeneWidth),
  localparam int GidxW      = (NumGenes > 1) ? $clog2(NumGenes) : 1,
  localparam int CntW       = $clog2(NumGenes + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ChromWidth-1:0] in_chrom,
  input  logic [Width-1:0]      rate,
  input  logic [Width-1:0]      rnd_in,
  output logic                  rnd_ce,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ChromWidth-1:0] out_chrom,
  output logic [CntW-1:0]       mut_count
`ifdef MUTATION_STATS_EN
  ,
  output logic [31:0]           total_mut
`endif
);

  localparam logic [GidxW-1:0] LastGidx = GidxW'(NumGenes - 1);

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  rnd_ce_q, rnd_ce_d;
  logic                  out_valid_q, out_valid_d;
  logic [ChromWidth-1:0] chrom_q, chrom_d;
  logic [Width-1:0]      rate_q, rate_d;
  logic [GidxW-1:0]      gidx_q, gidx_d;
  logic                  phase_q, phase_d;
  logic                  hit_q, hit_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  accept_s;
  logic [GeneWidth-1:0]  cur_gene_s, new_gene_s;

  assign accept_s   = (state_q == IDLE) && in_valid && in_ready_q;
  assign cur_gene_s = chrom_q[gidx_q*GeneWidth +: GeneWidth];

  mutation_gene_flip #(.GeneWidth(GeneWidth), .IdxW(GeneIdxW)) u_flip (
    .gene_i    (cur_gene_s),
    .hit_i     (hit_q),
    .bit_idx_i (rnd_in[GeneIdxW-1:0]),
    .gene_o    (new_gene_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s) state_d = DRAW; else state_d = IDLE;
      DRAW:    if (phase_q && (gidx_q == LastGidx)) state_d = DONE; else state_d = DRAW;
      DONE:    if (out_ready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs follow the upcoming state so they are registered.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    rnd_ce_d    = (state_d == DRAW);
    out_valid_d = (state_d == DONE);
  end

  // Datapath: latch at accept, then alternate hit-draw and bit-draw per gene.
  always_comb begin
    chrom_d = chrom_q;
    rate_d  = rate_q;
    gidx_d  = gidx_q;
    phase_d = phase_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    if (accept_s) begin
      chrom_d = in_chrom;
      rate_d  = rate;
      gidx_d  = {GidxW{1'b0}};
      phase_d = 1'b0;
      hit_d   = 1'b0;
      cnt_d   = {CntW{1'b0}};
    end else if (state_q == DRAW) begin
      if (!phase_q) begin
        hit_d   = (rnd_in < rate_q);
        phase_d = 1'b1;
      end else begin
        chrom_d[gidx_q*GeneWidth +: GeneWidth] = new_gene_s;
        if (hit_q) cnt_d = cnt_q + CntW'(1); else cnt_d = cnt_q;
        if (gidx_q == LastGidx) gidx_d = {GidxW{1'b0}}; else gidx_d = gidx_q + GidxW'(1);
        phase_d = 1'b0;
      end
    end else begin
      chrom_d = chrom_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q  <= 1'b0;
      rnd_ce_q    <= 1'b0;
      out_valid_q <= 1'b0;
      chrom_q     <= {ChromWidth{1'b0}};
      rate_q      <= {Width{1'b0}};
      gidx_q      <= {GidxW{1'b0}};
      phase_q     <= 1'b0;
      hit_q       <= 1'b0;
      cnt_q       <= {CntW{1'b0}};
    end else begin
      in_ready_q  <= in_ready_d;
      rnd_ce_q    <= rnd_ce_d;
      out_valid_q <= out_valid_d;
      chrom_q     <= chrom_d;
      rate_q      <= rate_d;
      gidx_q      <= gidx_d;
      phase_q     <= phase_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign rnd_ce    = rnd_ce_q;
  assign out_valid = out_valid_q;
  assign out_chrom = chrom_q;
  assign mut_count = cnt_q;

`ifdef MUTATION_STATS_EN
  logic [31:0] total_q;

  // Running total of flipped genes over delivered chromosomes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= 32'h0000_0000;
    end else if (out_valid_q && out_ready) begin
      total_q <= sat_add32(total_q, 32'(cnt_q));
    end else begin
      total_q <= total_q;
    end
  end

  assign total_mut = total_q;
`endif

endmodule

// File: tb/tb_lca_mutation_unit.sv
// Scoreboard bench for lca_mutation_unit (Width=8, GeneWidth=8, NumGenes=4).
module tb_lca_mutation_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, rnd_ce, out_valid, out_ready;
  logic [31:0] in_chrom, out_chrom;
  logic [7:0]  rate, rnd_in;
  logic [2:0]  mut_count;
`ifdef MUTATION_STATS_EN
  logic [31:0] total_mut;
`endif

  typedef struct {
    logic [31:0] chrom;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  words [0:7];
  int unsigned total_ce = 0;
  int unsigned base_ce  = 0;
  logic [31:0] idx_s;
  logic [31:0] sum_exp  = 32'd0;
  int          checks_cnt = 0;
  int          errors_cnt = 0;

  always #5 clk = ~clk;

  // Words are presented in order; each consumed word advances the pointer.
  always @(posedge clk) if (rnd_ce) total_ce <= total_ce + 1;
  assign idx_s  = total_ce - base_ce;
  assign rnd_in = words[idx_s[2:0]];

  lca_mutation_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chrom  (in_chrom),
    .rate      (rate),
    .rnd_in    (rnd_in),
    .rnd_ce    (rnd_ce),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chrom (out_chrom),
    .mut_count (mut_count)
`ifdef MUTATION_STATS_EN
    ,
    .total_mut (total_mut)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_mut(input logic [31:0] c, input logic [7:0] r);
    exp_t e;
    logic [7:0] w0, w1;
    e.chrom = c;
    e.cnt   = 3'd0;
    for (int g = 0; g < 4; g++) begin
      w0 = words[2*g];
      w1 = words[2*g+1];
      if (w0 < r) begin
        e.chrom[g*8 + int'(w1[2:0])] = ~e.chrom[g*8 + int'(w1[2:0])];
        e.cnt = e.cnt + 3'd1;
      end
    end
    return e;
  endfunction

  task automatic fill_words(input logic [7:0] even_w, input logic [7:0] odd_w);
    for (int i = 0; i < 8; i++) words[i] = (i % 2 == 0) ? even_w : odd_w;
  endtask

  // Offer one chromosome, wait for the result, optionally stall, then take it.
  task automatic do_chrom(input logic [31:0] c, input logic [7:0] r,
                          input logic [31:0] exp_chrom, input logic [2:0] exp_cnt,
                          input int stall);
    exp_t e, got;
    int   k;
    e.chrom = exp_chrom;
    e.cnt   = exp_cnt;
    @(negedge clk);
    base_ce  = total_ce;
    in_chrom = c;
    rate     = r;
    in_valid = 1'b1;
    sb_q.push_back(e);
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    check_eq("in_ready_wait", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_chrom = $urandom;
    rate     = 8'($urandom);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 40);
    check_eq("latency", 64'(k), 64'd9);
    got = sb_q.pop_front();
    check_eq("out_chrom", {32'd0, out_chrom}, {32'd0, got.chrom});
    check_eq("mut_count", {61'd0, mut_count}, {61'd0, got.cnt});
    check_eq("ce_words", 64'(total_ce - base_ce), 64'd8);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_hold", {28'd0, out_valid, in_ready, rnd_ce, mut_count, out_chrom},
                             {28'd0, 1'b1, 1'b0, 1'b0, got.cnt, got.chrom});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    sum_exp   = sum_exp + 32'(got.cnt);
    check_eq("post_hs", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    exp_t e;
    logic [31:0] c;
    logic [7:0]  r;
    int          k;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_chrom = 32'd0; rate = 8'd0;
    fill_words(8'h00, 8'h00);
    #12;
    check_eq("reset_state", {28'd0, in_ready, rnd_ce, out_valid, mut_count, out_chrom}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    do_chrom(32'hDEADBEEF, 8'h00, 32'hDEADBEEF, 3'd0, 0);
    fill_words(8'h03, 8'h03);
    do_chrom(32'h00000000, 8'hFF, 32'h08080808, 3'd4, 0);
    fill_words(8'h10, 8'h05);
    do_chrom(32'h12345678, 8'h20, 32'h32147658, 3'd4, 0);
    do_chrom(32'h12345678, 8'h10, 32'h12345678, 3'd0, 0);
    fill_words(8'hFF, 8'h01);
    do_chrom(32'hA5A5A5A5, 8'hFF, 32'hA5A5A5A5, 3'd0, 0);
    fill_words(8'hFE, 8'h07);
    do_chrom(32'h0F0F0F0F, 8'hFF, 32'h8F8F8F8F, 3'd4, 5);

    // Reset in the middle of drawing (gene 2, phase 0) drops the chromosome.
    fill_words(8'h03, 8'h03);
    @(negedge clk);
    base_ce  = total_ce;
    in_chrom = 32'h00000000;
    rate     = 8'hFF;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("pre_rst_cnt", {61'd0, mut_count}, 64'd2);
    rst = 1'b0;
    #1;
    check_eq("mid_rst", {28'd0, in_ready, rnd_ce, out_valid, mut_count, out_chrom}, 64'd0);
    sum_exp = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    fill_words(8'h10, 8'h02);
    do_chrom(32'hFFFFFFFF, 8'h11, 32'hFBFBFBFB, 3'd4, 0);

    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
      c = $urandom;
      r = 8'($urandom);
      e = model_mut(c, r);
      do_chrom(c, r, e.chrom, e.cnt, n % 3);
    end

`ifdef MUTATION_STATS_EN
    check_eq("total_mut", {32'd0, total_mut}, {32'd0, sum_exp});
`endif
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
